flood_engine: RTL

Parametrised Flood-It game engine, the next generation of the game-logic core. It holds a square board of up to MAX_SIZE x MAX_SIZE cells, accepts a board image from the board generator, and applies one colour move per COLOR_SEL_SIG pulse. Each move is a sequential flood-fill from cell (0,0), with a move counter, an optional move limit, and win/lose detection. It sits between the selector/generator and the VGA renderer, which reads cells through a combinational read port.

---
 rtl/flood_engine.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/flood_engine.sv
// Flood-It game core: holds the board, seeds ownership at (0,0) on START and grows
// the owned region with repeated row-major sweeps after every accepted colour move.
module flood_engine #(
    parameter  int MAX_SIZE = 26,
    parameter  int CW       = 3,
    parameter  int MOVE_W   = 8,
    localparam int AW       = $clog2(MAX_SIZE),
    localparam int SW       = $clog2(MAX_SIZE + 1)
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic [SW-1:0]     SIZE,
    input  logic [CW:0]       COLOR_NUM,
    input  logic [MOVE_W-1:0] MAX_MOVES,
    input  logic              LOAD_EN,
    input  logic [AW-1:0]     LOAD_ROW,
    input  logic [AW-1:0]     LOAD_COL,
    input  logic [CW-1:0]     LOAD_COLOR,
    input  logic              START,
    input  logic              COLOR_SEL_SIG,
    input  logic [CW-1:0]     COLOR_SELECTED,
    input  logic [AW-1:0]     RD_ROW,
    input  logic [AW-1:0]     RD_COL,
    output logic [CW-1:0]     RD_COLOR,
    output logic              BUSY,
    output logic [MOVE_W-1:0] MOVES,
    output logic              WON,
    output logic              LOST
);
    localparam int OCW = $clog2(MAX_SIZE * MAX_SIZE + 1);

    typedef enum logic [2:0] {IDLE, SEED, PLAY, PAINT, SWEEP, CHECK, OVER} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]     color_q [MAX_SIZE][MAX_SIZE];
    logic              owned_q [MAX_SIZE][MAX_SIZE];
    logic [OCW-1:0]    owned_cnt_q;
    logic [SW-1:0]     size_q;
    logic [CW:0]       num_q;
    logic [MOVE_W-1:0] max_q;
    logic [MOVE_W-1:0] moves_q;
    logic [CW-1:0]     target_q;
    logic [AW-1:0]     row_q;
    logic [AW-1:0]     col_q;
    logic              changed_q;
    logic              won_q;
    logic              lost_q;

    int            size_i;
    logic [AW-1:0] r_up, r_dn, c_lf, c_rt;
    logic [SW-1:0] size_cl;
    logic          nbr, grow, row_end, last_cell;
    logic          load_ok, start_ok, move_ok, won_hit, lost_hit;

    assign size_i = int'(size_q);

    always_comb begin
        // At a board edge the neighbour index folds back onto the cell itself,
        // which is never owned when it is a grow candidate, so it adds nothing.
        r_up      = (row_q == '0) ? row_q : row_q - 1'b1;
        c_lf      = (col_q == '0) ? col_q : col_q - 1'b1;
        r_dn      = (int'(row_q) + 1 < size_i) ? row_q + 1'b1 : row_q;
        c_rt      = (int'(col_q) + 1 < size_i) ? col_q + 1'b1 : col_q;
        nbr       = owned_q[r_up][col_q] | owned_q[r_dn][col_q] |
                    owned_q[row_q][c_lf] | owned_q[row_q][c_rt];
        grow      = (state_q == SWEEP) && !owned_q[row_q][col_q] &&
                    (color_q[row_q][col_q] == target_q) && nbr;
        row_end   = (int'(col_q) == size_i - 1);
        last_cell = row_end && (int'(row_q) == size_i - 1);
        load_ok   = ((state_q == IDLE) || (state_q == OVER)) && LOAD_EN &&
                    (int'(LOAD_ROW) < MAX_SIZE) && (int'(LOAD_COL) < MAX_SIZE);
        start_ok  = ((state_q == IDLE) || (state_q == OVER)) && START;
        move_ok   = (state_q == PLAY) && COLOR_SEL_SIG &&
                    ({1'b0, COLOR_SELECTED} < num_q) && (COLOR_SELECTED != target_q);
        won_hit   = (int'(owned_cnt_q) == size_i * size_i);
        lost_hit  = (max_q != '0) && (moves_q == max_q);
        if (int'(SIZE) < 2)
            size_cl = SW'(2);
        else if (int'(SIZE) > MAX_SIZE)
            size_cl = SW'(MAX_SIZE);
        else
            size_cl = SIZE;
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, OVER: if (start_ok) state_d = SEED;
            SEED:       state_d = SWEEP;
            PLAY:       if (move_ok) state_d = PAINT;
            PAINT:      state_d = SWEEP;
            SWEEP:      if (last_cell && !(changed_q || grow)) state_d = CHECK;
            CHECK:      state_d = (won_hit || lost_hit) ? OVER : PLAY;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            for (int r = 0; r < MAX_SIZE; r++)
                for (int c = 0; c < MAX_SIZE; c++) begin
                    color_q[r][c] <= '0;
                    owned_q[r][c] <= 1'b0;
                end
            owned_cnt_q <= '0;
            size_q      <= SW'(MAX_SIZE);
            num_q       <= '0;
            max_q       <= '0;
            moves_q     <= '0;
            target_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            changed_q   <= 1'b0;
            won_q       <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            if (load_ok)
                color_q[LOAD_ROW][LOAD_COL] <= LOAD_COLOR;
            if (start_ok) begin
                size_q <= size_cl;
                num_q  <= COLOR_NUM;
                max_q  <= MAX_MOVES;
            end
            case (state_q)
                SEED: begin
                    for (int r = 0; r < MAX_SIZE; r++)
                        for (int c = 0; c < MAX_SIZE; c++)
                            owned_q[r][c] <= 1'b0;
                    owned_q[0][0] <= 1'b1;
                    owned_cnt_q   <= OCW'(1);
                    target_q      <= color_q[0][0];
                    moves_q       <= '0;
                    won_q         <= 1'b0;
                    lost_q        <= 1'b0;
                    row_q         <= '0;
                    col_q         <= '0;
                    changed_q     <= 1'b0;
                end
                PLAY: if (move_ok) begin
                    target_q <= COLOR_SELECTED;
                    if (moves_q != '1)
                        moves_q <= moves_q + 1'b1;
                end
                PAINT: begin
                    for (int r = 0; r < MAX_SIZE; r++)
                        for (int c = 0; c < MAX_SIZE; c++)
                            if (owned_q[r][c])
                                color_q[r][c] <= target_q;
                    row_q     <= '0;
                    col_q     <= '0;
                    changed_q <= 1'b0;
                end
                SWEEP: begin
                    if (grow) begin
                        owned_q[row_q][col_q] <= 1'b1;
                        owned_cnt_q           <= owned_cnt_q + 1'b1;
                    end
                    if (row_end) begin
                        col_q <= '0;
                        row_q <= last_cell ? '0 : row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                    changed_q <= last_cell ? 1'b0 : (changed_q | grow);
                end
                CHECK: begin
                    if (won_hit)
                        won_q <= 1'b1;
                    else if (lost_hit)
                        lost_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        RD_COLOR = '0;
        if ((int'(RD_ROW) < size_i) && (int'(RD_COL) < size_i))
            RD_COLOR = color_q[RD_ROW][RD_COL];
    end

    assign BUSY  = (state_q == SEED) || (state_q == PAINT) ||
                   (state_q == SWEEP) || (state_q == CHECK);
    assign MOVES = moves_q;
    assign WON   = won_q;
    assign LOST  = lost_q;
endmodule
